mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state on rising edge); rst input 1 (synchronous, active-high).
REQ-002 ex_valid input 1: EX presents a valid instruction this cycle.
REQ-003 ex_aluop input 8: operation code, from the shared opcode set.
REQ-004 ex_wd input 5: destination register address.
REQ-005 ex_wreg input 1: instruction writes the register file.
REQ-006 ex_wdata input 32: ALU result for non-memory operations.
REQ-007 ex_mem_addr input 32: effective byte address.
REQ-008 ex_mem_data input 32: store data, right-justified.
REQ-009 stall_req output 1: combinational; EX SHALL hold all ex_* inputs stable while it is high.
REQ-010 mem_req output 1, mem_we output 1, mem_addr output 32, mem_sel output 4 and mem_wdata output 32: registered data-bus request.
REQ-011 mem_ack input 1 and mem_rdata input 32: bus completion and read word, both valid in the ack cycle.
REQ-012 wb_wd output 5, wb_wreg output 1 and wb_wdata output 32: registered; they drive the regfile write port (waddr/we/wdata) directly.
REQ-013 misalign_err output 1: registered one-cycle pulse.

Function
REQ-014 The FSM SHALL have two states: IDLE and BUSY.
REQ-015 IDLE, non-memory op with ex_valid=1: next edge wb_wd=ex_wd, wb_wreg=ex_wreg, wb_wdata=ex_wdata (1-cycle latency); stall_req=0.
REQ-016 IDLE, ex_valid=0: next edge wb_wreg=0 (bubble).
REQ-017 IDLE, aligned memory op: stall_req=1 the same cycle; next edge state=BUSY, mem_req=1, and address/we/sel/wdata are latched; wb_wreg=0.
REQ-018 BUSY, mem_ack=0: mem_req and all request fields SHALL be held constant; stall_req=1; wb_wreg=0 each edge.
REQ-019 BUSY, mem_ack=1: stall_req=0 that cycle; next edge mem_req=0, state=IDLE, and the wb_* outputs are loaded (loads: aligned data with ex_wreg; stores: wb_wreg=0).
REQ-020 Minimum load latency: op in cycle 0, request in cycle 1, ack in cycle 1, write-back valid in cycle 2.
REQ-021 mem_ack while IDLE SHALL be ignored.
REQ-022 The bus is big-endian: mem_addr={addr[31:2],2'b00}. Byte access: sel=1000/0100/0010/0001 for addr[1:0]=00/01/10/11. Halfword access: sel=1100 for addr[1]=0, 0011 for addr[1]=1. Word access: sel=1111.
REQ-023 Stores SHALL replicate data across lanes: SB {4{d[7:0]}}, SH {2{d[15:0]}}, SW d.
REQ-024 Loads SHALL extract the selected lane: LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-025 Misalignment is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. Such an op SHALL raise no bus request, stay IDLE, set stall_req=0, and at the next edge set wb_wreg=0 and misalign_err=1 for one cycle.
REQ-026 A load with ex_wd=0 SHALL still perform the bus access; write suppression is the regfile's job.
REQ-027 Back-to-back memory ops: the second op SHALL enter from IDLE on the cycle after the write-back edge; there is no request overlap.

Reset
REQ-028 With rst=1 at an edge: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_sel=0, mem_wdata=0, wb_wd=0, wb_wreg=0, wb_wdata=0, misalign_err=0.
REQ-029 While rst=1, stall_req SHALL be 0.
REQ-030 Reset in BUSY SHALL abandon the request (mem_req=0 next edge); an ack arriving after that SHALL be ignored.

Structure
REQ-031 The load/store aluop codes SHALL live in the shared define file with the other constants: LB E0, LBU E4, LH E1, LHU E5, LW E3, SB E8, SH E9, SW EB (hex).
REQ-032 The FSM state encodings SHALL also live in the shared define file.
REQ-033 The load-lane extraction and extension SHALL be one combinational sub-module, mem_load_align.

Verification
REQ-034 ALU op ex_wd=3, ex_wreg=1, ex_wdata=0x0000002A -> next edge wb_wd=3, wb_wreg=1, wb_wdata=0x2A; stall_req stays 0.
REQ-035 LB addr=0x101, mem_rdata=0x11F23344, ack after 2 wait cycles -> mem_sel=0100, stall_req high for 3 cycles, wb_wdata=0xFFFFFFF2.
REQ-036 SH addr=0x202, data=0x0000BEEF, immediate ack -> mem_we=1, mem_addr=0x200, mem_sel=0011, mem_wdata=0xBEEFBEEF, wb_wreg=0.
REQ-037 LW addr=0x103 -> mem_req stays 0, misalign_err one pulse, wb_wreg=0.
REQ-038 LHU addr=0x300, rdata=0x8001xxxx, with rst=1 asserted in BUSY -> all outputs zero next edge, no write-back; after reset release an ALU op completes normally.
REQ-039 LW then dependent ALU op back-to-back -> each op produces exactly one wb_wreg=1 pulse, and mem_req deasserts between the two ops.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants for the memory-access stage: load/store opcodes, FSM
// state encoding and the lane/alignment helpers used by the stage and its aligner.
package mem_access_pkg;

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic size_t op_size(input logic [7:0] op);
        if (op inside {OP_LB, OP_LBU, OP_SB}) return SZ_BYTE;
        if (op inside {OP_LH, OP_LHU, OP_SH}) return SZ_HALF;
        return SZ_WORD;
    endfunction

    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] lo);
        case (op_size(op))
            SZ_HALF: return lo[0];
            SZ_WORD: return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Big-endian lanes: byte address 0 sits in bits [31:24].
    function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] lo);
        case (op_size(op))
            SZ_BYTE: return 4'b1000 >> lo;
            SZ_HALF: return lo[1] ? 4'b0011 : 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] d);
        case (op_size(op))
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed lane out of a big-endian read word and sign- or
// zero-extends it according to the load opcode.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sign_ext;

    always_comb begin
        case (addr_lo)
            2'b00:   lane_b = rdata[31:24];
            2'b01:   lane_b = rdata[23:16];
            2'b10:   lane_b = rdata[15:8];
            default: lane_b = rdata[7:0];
        endcase
        lane_h   = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        sign_ext = (aluop == OP_LB) || (aluop == OP_LH);

        case (op_size(aluop))
            SZ_BYTE: data = {{24{sign_ext & lane_b[7]}}, lane_b};
            SZ_HALF: data = {{16{sign_ext & lane_h[15]}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through in one cycle and
// runs loads/stores over a single-outstanding data bus, stalling EX meanwhile.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [7:0]  ex_aluop,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_mem_data,
    output logic        stall_req,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        misalign_err
);

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_sel_q, mem_sel_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]  op_q, op_d;
    logic [1:0]  lo_q, lo_d;
    logic [4:0]  wb_wd_q, wb_wd_d;
    logic        wb_wreg_q, wb_wreg_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic        misalign_err_q, misalign_err_d;
    logic [31:0] load_data;

    // The request's opcode and byte offset are kept so the ack-cycle
    // extraction never depends on the low address bits dropped from mem_addr.
    mem_load_align u_align (
        .aluop   (op_q),
        .addr_lo (lo_q),
        .rdata   (mem_rdata),
        .data    (load_data)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_sel_d      = mem_sel_q;
        mem_wdata_d    = mem_wdata_q;
        op_d           = op_q;
        lo_d           = lo_q;
        wb_wd_d        = wb_wd_q;
        wb_wreg_d      = 1'b0;
        wb_wdata_d     = wb_wdata_q;
        misalign_err_d = 1'b0;
        stall_req      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (is_load(ex_aluop) || is_store(ex_aluop)) begin
                        if (misaligned(ex_aluop, ex_mem_addr[1:0])) begin
                            misalign_err_d = 1'b1;
                        end else begin
                            stall_req   = 1'b1;
                            state_d     = ST_BUSY;
                            mem_req_d   = 1'b1;
                            mem_we_d    = is_store(ex_aluop);
                            mem_addr_d  = {ex_mem_addr[31:2], 2'b00};
                            mem_sel_d   = lane_sel(ex_aluop, ex_mem_addr[1:0]);
                            mem_wdata_d = store_data(ex_aluop, ex_mem_data);
                            op_d        = ex_aluop;
                            lo_d        = ex_mem_addr[1:0];
                        end
                    end else begin
                        wb_wd_d    = ex_wd;
                        wb_wreg_d  = ex_wreg;
                        wb_wdata_d = ex_wdata;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    if (!is_store(op_q)) begin
                        // EX is still holding the load, so its wd/wreg are current.
                        wb_wd_d    = ex_wd;
                        wb_wreg_d  = ex_wreg;
                        wb_wdata_d = load_data;
                    end
                end else begin
                    stall_req = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst) stall_req = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_sel_q      <= '0;
            mem_wdata_q    <= '0;
            op_q           <= '0;
            lo_q           <= '0;
            wb_wd_q        <= '0;
            wb_wreg_q      <= 1'b0;
            wb_wdata_q     <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_sel_q      <= mem_sel_d;
            mem_wdata_q    <= mem_wdata_d;
            op_q           <= op_d;
            lo_q           <= lo_d;
            wb_wd_q        <= wb_wd_d;
            wb_wreg_q      <= wb_wreg_d;
            wb_wdata_q     <= wb_wdata_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_sel      = mem_sel_q;
    assign mem_wdata    = mem_wdata_q;
    assign wb_wd        = wb_wd_q;
    assign wb_wreg      = wb_wreg_q;
    assign wb_wdata     = wb_wdata_q;
    assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: directed scenarios plus random load/store/ALU ops,
// checked against an arithmetic reference model of the bus lanes and extension.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [7:0]  ex_aluop;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_data;
    logic        stall_req;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        misalign_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_aluop     (ex_aluop),
        .ex_wd        (ex_wd),
        .ex_wreg      (ex_wreg),
        .ex_wdata     (ex_wdata),
        .ex_mem_addr  (ex_mem_addr),
        .ex_mem_data  (ex_mem_data),
        .stall_req    (stall_req),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_sel      (mem_sel),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .wb_wd        (wb_wd),
        .wb_wreg      (wb_wreg),
        .wb_wdata     (wb_wdata),
        .misalign_err (misalign_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access width in bytes (0 = not a memory op).
    function automatic int op_bytes(input logic [7:0] op);
        case (op)
            8'hE0, 8'hE4, 8'hE8: return 1;
            8'hE1, 8'hE5, 8'hE9: return 2;
            8'hE3, 8'hEB:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit op_is_store(input logic [7:0] op);
        return (op == 8'hE8) || (op == 8'hE9) || (op == 8'hEB);
    endfunction

    function automatic bit op_signed(input logic [7:0] op);
        return (op == 8'hE0) || (op == 8'hE1);
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] op, input int lo, input logic [31:0] rdata);
        int s = op_bytes(op);
        logic [31:0] v;
        v = rdata >> (8 * (4 - s - lo));
        if (s < 4) begin
            v = v & ((32'd1 << (8 * s)) - 32'd1);
            if (op_signed(op) && v[8 * s - 1]) v = v - (32'd1 << (8 * s));
        end
        return v;
    endfunction

    task automatic run_op(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] alu, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata, input int waits);
        int s = op_bytes(op);
        int lo = int'(addr[1:0]);
        bit mis = (s != 0) && ((lo % s) != 0);
        logic [3:0]  exp_sel;
        logic [31:0] exp_wdata;
        ex_valid = 1'b1;
        ex_aluop = op;
        ex_wd = wd;
        ex_wreg = wreg;
        ex_wdata = alu;
        ex_mem_addr = addr;
        ex_mem_data = sdata;
        mem_ack = 1'b0;
        #1;
        check("stall_issue", 32'(stall_req), 32'((s != 0 && !mis) ? 1 : 0));
        if (s == 0) begin
            tick();
            check("alu_wreg", 32'(wb_wreg), 32'(wreg));
            check("alu_wd", 32'(wb_wd), 32'(wd));
            check("alu_wdata", wb_wdata, alu);
            check("alu_no_req", 32'(mem_req), 32'd0);
        end else if (mis) begin
            tick();
            ex_valid = 1'b0;
            check("mis_no_req", 32'(mem_req), 32'd0);
            check("mis_err", 32'(misalign_err), 32'd1);
            check("mis_wreg", 32'(wb_wreg), 32'd0);
            tick();
            check("mis_err_pulse", 32'(misalign_err), 32'd0);
        end else begin
            exp_sel = 4'(((1 << s) - 1) << (4 - s - lo));
            exp_wdata = (s == 1) ? 32'(sdata[7:0]) * 32'h0101_0101 :
                        (s == 2) ? 32'(sdata[15:0]) * 32'h0001_0001 : sdata;
            tick();
            check("req", 32'(mem_req), 32'd1);
            check("req_we", 32'(mem_we), 32'(op_is_store(op)));
            check("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
            check("req_sel", 32'(mem_sel), 32'(exp_sel));
            if (op_is_store(op)) check("req_wdata", mem_wdata, exp_wdata);
            check("req_wreg", 32'(wb_wreg), 32'd0);
            for (int w = 0; w < waits; w++) begin
                check("wait_stall", 32'(stall_req), 32'd1);
                tick();
                check("wait_req", 32'(mem_req), 32'd1);
                check("wait_addr", mem_addr, addr & 32'hFFFF_FFFC);
                check("wait_sel", 32'(mem_sel), 32'(exp_sel));
                check("wait_wreg", 32'(wb_wreg), 32'd0);
            end
            mem_ack = 1'b1;
            mem_rdata = rdata;
            #1;
            check("ack_stall", 32'(stall_req), 32'd0);
            tick();
            mem_ack = 1'b0;
            ex_valid = 1'b0;
            check("done_req", 32'(mem_req), 32'd0);
            if (op_is_store(op)) begin
                check("st_wreg", 32'(wb_wreg), 32'd0);
            end else begin
                check("ld_wreg", 32'(wb_wreg), 32'(wreg));
                if (wreg) check("ld_wd", 32'(wb_wd), 32'(wd));
                check("ld_data", wb_wdata, model_load(op, lo, rdata));
            end
        end
    endtask

    task automatic bubble();
        ex_valid = 1'b0;
        tick();
        check("bubble_wreg", 32'(wb_wreg), 32'd0);
    endtask

    initial begin
        logic [7:0] mem_ops [8];
        logic [7:0] alu_ops [4];
        mem_ops = '{8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE8, 8'hE9, 8'hEB};
        alu_ops = '{8'h00, 8'h21, 8'h24, 8'h25};

        rst = 1'b1;
        ex_valid = 1'b1;
        ex_aluop = 8'hE3;
        ex_wd = 5'd7;
        ex_wreg = 1'b1;
        ex_wdata = 32'h1234_5678;
        ex_mem_addr = 32'h0000_0100;
        ex_mem_data = 32'hDEAD_BEEF;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        tick();
        tick();
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_sel", 32'(mem_sel), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wb_wd", 32'(wb_wd), 32'd0);
        check("rst_wb_wreg", 32'(wb_wreg), 32'd0);
        check("rst_wb_wdata", wb_wdata, 32'd0);
        check("rst_mis", 32'(misalign_err), 32'd0);
        ex_valid = 1'b0;
        rst = 1'b0;

        // Ack with nothing outstanding must be ignored.
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_req", 32'(mem_req), 32'd0);
        check("idle_ack_wreg", 32'(wb_wreg), 32'd0);

        run_op(8'h21, 5'd3, 1'b1, 32'h0000_002A, 32'h0, 32'h0, 32'h0, 0);
        bubble();

        run_op(8'hE0, 5'd9, 1'b1, 32'h0, 32'h0000_0101, 32'h0, 32'h11F2_3344, 2);
        check("lb_example", wb_wdata, 32'hFFFF_FFF2);

        run_op(8'hE9, 5'd4, 1'b1, 32'h0, 32'h0000_0202, 32'h0000_BEEF, 32'h0, 0);
        check("sh_example_wreg", 32'(wb_wreg), 32'd0);

        run_op(8'hE3, 5'd5, 1'b1, 32'h0, 32'h0000_0103, 32'h0, 32'h0, 0);

        // Reset while a request is outstanding abandons it; a late ack is ignored.
        ex_valid = 1'b1;
        ex_aluop = 8'hE5;
        ex_wd = 5'd6;
        ex_wreg = 1'b1;
        ex_mem_addr = 32'h0000_0300;
        #1;
        check("rb_stall", 32'(stall_req), 32'd1);
        tick();
        check("rb_req", 32'(mem_req), 32'd1);
        check("rb_sel", 32'(mem_sel), 32'hC);
        rst = 1'b1;
        #1;
        check("rb_stall_in_rst", 32'(stall_req), 32'd0);
        tick();
        rst = 1'b0;
        ex_valid = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h8001_5A5A;
        check("rb_req_clr", 32'(mem_req), 32'd0);
        check("rb_addr_clr", mem_addr, 32'd0);
        check("rb_sel_clr", 32'(mem_sel), 32'd0);
        check("rb_wreg", 32'(wb_wreg), 32'd0);
        check("rb_wdata", wb_wdata, 32'd0);
        #1;
        check("rb_late_ack_stall", 32'(stall_req), 32'd0);
        tick();
        mem_ack = 1'b0;
        check("rb_late_ack_req", 32'(mem_req), 32'd0);
        check("rb_late_ack_wreg", 32'(wb_wreg), 32'd0);
        run_op(8'h24, 5'd11, 1'b1, 32'hCAFE_0001, 32'h0, 32'h0, 32'h0, 0);

        // Load followed immediately by a dependent ALU op.
        run_op(8'hE3, 5'd12, 1'b1, 32'h0, 32'h0000_0400, 32'h0, 32'hA5A5_0F0F, 0);
        run_op(8'h00, 5'd13, 1'b1, 32'hA5A5_0F10, 32'h0, 32'h0, 32'h0, 0);
        bubble();

        // A load to r0 still goes to the bus.
        run_op(8'hE4, 5'd0, 1'b1, 32'h0, 32'h0000_0503, 32'h0, 32'h0000_0080, 1);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] op;
            if ($urandom_range(0, 3) == 0) op = alu_ops[$urandom_range(0, 3)];
            else                           op = mem_ops[$urandom_range(0, 7)];
            run_op(op, 5'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) bubble();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
